key_cmd_sched: RTL and testbench

KEY_CMD_SCHED -- requirements
Module: key_cmd_sched

---
 rtl/key_cmd_sched.sv | 192 +++++++++++++++++++
 tb/tb_key_cmd_sched.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_sched.sv
`default_nettype none
// ============================================================================
// key_cmd_sched -- latches key presses, queues them and issues paced commands.
// Define KEY_CMD_SCHED_FIXED_PRIO_EN for fixed priority arbitration. Rev 1.0
// ============================================================================
module key_cmd_sched #(
  parameter int GAP_CYCLES = 25_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_add,
  input  logic                        req_sub,
  input  logic                        req_shl,
  input  logic                        req_shr,
  input  logic                        cmd_ready,
  output logic                        cmd_valid,
  output logic [1:0]                  cmd_code,
  output logic                        key_add,
  output logic                        key_sub,
  output logic                        key_shift_left,
  output logic                        key_shift_right,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  logic [3:0]    req_vec;
  logic [3:0]    pending;
  logic [3:0]    grant;
  logic [1:0]    grant_idx;
  logic          found;
  logic          can_push;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          handshake;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  state_t        state;
  state_t        state_next;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_next;
  logic          valid_next;
  logic [1:0]    code_next;

  assign req_vec  = {req_shr, req_shl, req_sub, req_add};
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign pop      = (state == S_IDLE) && !empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts a push.
  assign can_push = !full || pop;
  assign push     = found && can_push;
  assign grant    = push ? (4'b0001 << grant_idx) : 4'b0000;

`ifdef KEY_CMD_SCHED_FIXED_PRIO_EN
  always_comb begin
    found     = 1'b0;
    grant_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!found && pending[k]) begin
        found     = 1'b1;
        grant_idx = 2'(k);
      end
    end
  end
`else
  logic [1:0] rr_ptr;

  always_comb begin
    found     = 1'b0;
    grant_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!found && pending[rr_ptr + 2'(k)]) begin
        found     = 1'b1;
        grant_idx = rr_ptr + 2'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 2'd0;
    end else if (push) begin
      rr_ptr <= grant_idx + 2'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 4'b0000;
      overflow <= 1'b0;
    end else begin
      pending  <= (pending & ~grant) | (req_vec & ~pending);
      overflow <= overflow | (|(req_vec & pending));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    valid_next = cmd_valid;
    code_next  = cmd_code;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_next = S_ISSUE;
          valid_next = 1'b1;
          code_next  = mem[rd_ptr];
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          valid_next = 1'b0;
          gap_next   = '0;
          state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = S_IDLE;
        end else begin
          gap_next = gap_cnt + GW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      gap_cnt   <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= 2'd0;
    end else begin
      state     <= state_next;
      gap_cnt   <= gap_next;
      cmd_valid <= valid_next;
      cmd_code  <= code_next;
    end
  end

  // Pulses are suppressed while reset is held so a queued command never leaks out.
  assign handshake       = cmd_valid && cmd_ready && !reset;
  assign key_add         = handshake && (cmd_code == 2'd0);
  assign key_sub         = handshake && (cmd_code == 2'd1);
  assign key_shift_left  = handshake && (cmd_code == 2'd2);
  assign key_shift_right = handshake && (cmd_code == 2'd3);
  assign fifo_count      = count;

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_sched.sv
`default_nettype none
// tb_key_cmd_sched -- directed and randomized checks of key_cmd_sched against a
// queue-level reference model (GAP_CYCLES=3, FIFO_DEPTH=4).
module tb_key_cmd_sched;

  localparam int GAP   = 3;
  localparam int DEPTH = 4;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       req_add   = 1'b0;
  logic       req_sub   = 1'b0;
  logic       req_shl   = 1'b0;
  logic       req_shr   = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       key_add;
  logic       key_sub;
  logic       key_shift_left;
  logic       key_shift_right;
  logic [2:0] fifo_count;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  logic [3:0] key_now;
  logic [3:0] exp_key;

  // Reference model state: pending presses, command queue, presented command,
  // remaining quiet cycles and the next preferred request index.
  bit [3:0]   m_pend  = 4'b0000;
  int         m_q[$];
  bit         m_valid = 1'b0;
  logic [1:0] m_code  = 2'd0;
  int         m_gap   = 0;
  int         m_next  = 0;
  bit         m_ovf   = 1'b0;

  logic [3:0] col_key [8];
  int         col_at  [8];
  int         col_n;

  always #5 clk = ~clk;

  key_cmd_sched #(
    .GAP_CYCLES(GAP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_add        (req_add),
    .req_sub        (req_sub),
    .req_shl        (req_shl),
    .req_shr        (req_shr),
    .cmd_ready      (cmd_ready),
    .cmd_valid      (cmd_valid),
    .cmd_code       (cmd_code),
    .key_add        (key_add),
    .key_sub        (key_sub),
    .key_shift_left (key_shift_left),
    .key_shift_right(key_shift_right),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  function automatic void model_step(input logic [3:0] r, input logic rdy, input logic rst);
    bit [3:0] old;
    bit       pop;
    int       start;
    int       gi;
    if (rst) begin
      m_pend = 4'b0000;
      m_q.delete();
      m_valid = 1'b0;
      m_code  = 2'd0;
      m_gap   = 0;
      m_next  = 0;
      m_ovf   = 1'b0;
      return;
    end
    old = m_pend;
    pop = !m_valid && (m_gap == 0) && (m_q.size() > 0);
    if (m_valid && rdy) begin
      m_valid = 1'b0;
      m_gap   = GAP;
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end else if (pop) begin
      m_valid = 1'b1;
      m_code  = 2'(m_q.pop_front());
    end
    if (m_q.size() < DEPTH) begin
`ifdef KEY_CMD_SCHED_FIXED_PRIO_EN
      start = 0;
`else
      start = m_next;
`endif
      for (int k = 0; k < 4; k++) begin
        gi = (start + k) % 4;
        if (old[gi]) begin
          m_q.push_back(gi);
          m_pend[gi] = 1'b0;
          m_next = (gi + 1) % 4;
          break;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        if (old[i]) m_ovf = 1'b1;
        else        m_pend[i] = 1'b1;
      end
    end
  endfunction

  // One clock: drive on the falling edge, sample the one-hot outputs before the
  // rising edge, advance the model on the rising edge, settle 1 ns after it.
  task automatic cyc(input logic [3:0] r, input logic rdy, input logic rst);
    @(negedge clk);
    {req_shr, req_shl, req_sub, req_add} = r;
    cmd_ready = rdy;
    reset     = rst;
    #1;
    key_now = {key_shift_right, key_shift_left, key_sub, key_add};
    exp_key = (m_valid && rdy && !rst) ? (4'b0001 << m_code) : 4'b0000;
    @(posedge clk);
    model_step(r, rdy, rst);
    #1;
    ncyc++;
  endtask

  task automatic collect(input int want, input int budget);
    col_n = 0;
    for (int i = 0; i < budget && col_n < want; i++) begin
      cyc(4'b0000, 1'b1, 1'b0);
      if (key_now != 4'b0000) begin
        col_key[col_n] = key_now;
        col_at[col_n]  = ncyc;
        col_n++;
      end
    end
  endtask

  task automatic test_reset();
    cyc(4'b1111, 1'b1, 1'b1);
    cyc(4'b0000, 1'b1, 1'b1);
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", cmd_valid); end
    total++; if (cmd_code !== 2'd0) begin bad++; $display("FAIL reset_code got=%0d want=0", cmd_code); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (key_now !== 4'b0000) begin bad++; $display("FAIL reset_keys got=%b want=0000", key_now); end
    cyc(4'b0000, 1'b1, 1'b0);
    total++; if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      bad++; $display("FAIL post_reset_idle valid=%b count=%0d want 0/0", cmd_valid, fifo_count);
    end
  endtask

  task automatic test_single();
    cyc(4'b0000, 1'b1, 1'b1);
    cyc(4'b0001, 1'b1, 1'b0);
    total++; if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      bad++; $display("FAIL single_e0 valid=%b count=%0d want 0/0", cmd_valid, fifo_count);
    end
    cyc(4'b0000, 1'b1, 1'b0);
    total++; if (cmd_valid !== 1'b0 || fifo_count !== 3'd1) begin
      bad++; $display("FAIL single_e1 valid=%b count=%0d want 0/1", cmd_valid, fifo_count);
    end
    cyc(4'b0000, 1'b1, 1'b0);
    total++; if (cmd_valid !== 1'b1 || cmd_code !== 2'd0 || fifo_count !== 3'd0) begin
      bad++; $display("FAIL single_e2 valid=%b code=%0d count=%0d want 1/0/0", cmd_valid, cmd_code, fifo_count);
    end
    cyc(4'b0000, 1'b1, 1'b0);
    total++; if (key_now !== 4'b0001) begin bad++; $display("FAIL single_key got=%b want=0001", key_now); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL single_drop got=%b want=0", cmd_valid); end
    cyc(4'b0000, 1'b1, 1'b0);
    total++; if (key_now !== 4'b0000) begin bad++; $display("FAIL single_key_width got=%b want=0000", key_now); end
  endtask

  task automatic test_all_four();
    cyc(4'b0000, 1'b1, 1'b1);
    cyc(4'b1111, 1'b1, 1'b0);
    collect(4, 40);
    total++; if (col_n != 4) begin bad++; $display("FAIL all4_count got=%0d want=4", col_n); end
    for (int k = 0; k < col_n; k++) begin
      total++; if (col_key[k] !== (4'b0001 << k)) begin
        bad++; $display("FAIL all4_order idx=%0d got=%b want=%b", k, col_key[k], 4'b0001 << k);
      end
      if (k > 0) begin
        total++; if (col_at[k] - col_at[k-1] != GAP + 2) begin
          bad++; $display("FAIL all4_spacing idx=%0d got=%0d want=%0d", k, col_at[k] - col_at[k-1], GAP + 2);
        end
      end
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL all4_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_hold_overflow();
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    total++; if (cmd_valid !== 1'b1 || cmd_code !== 2'd0 || fifo_count !== 3'd3) begin
      bad++; $display("FAIL hold_first valid=%b code=%0d count=%0d want 1/0/3", cmd_valid, cmd_code, fifo_count);
    end
    cyc(4'b0001, 1'b0, 1'b0);
    total++; if (overflow !== 1'b0 || fifo_count !== 3'd3) begin
      bad++; $display("FAIL hold_second_add ovf=%b count=%0d want 0/3", overflow, fifo_count);
    end
    cyc(4'b0001, 1'b0, 1'b0);
    total++; if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
      bad++; $display("FAIL hold_third_add ovf=%b count=%0d want 1/4", overflow, fifo_count);
    end
    repeat (3) cyc(4'b0000, 1'b0, 1'b0);
    total++; if (cmd_valid !== 1'b1 || cmd_code !== 2'd0 || overflow !== 1'b1) begin
      bad++; $display("FAIL hold_stable valid=%b code=%0d ovf=%b want 1/0/1", cmd_valid, cmd_code, overflow);
    end
    collect(5, 80);
    total++; if (col_n != 5) begin bad++; $display("FAIL hold_drain_count got=%0d want=5", col_n); end
    for (int k = 0; k < col_n; k++) begin
      total++; if (col_key[k] !== exp_seq[k]) begin
        bad++; $display("FAIL hold_drain_order idx=%0d got=%b want=%b", k, col_key[k], exp_seq[k]);
      end
    end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL hold_drained got=%0d want=0", fifo_count); end
  endtask

  task automatic test_reset_mid_issue();
    int pulses;
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b1111, 1'b0, 1'b0);
    repeat (4) cyc(4'b0000, 1'b0, 1'b0);
    total++; if (cmd_valid !== 1'b1 || fifo_count !== 3'd3) begin
      bad++; $display("FAIL mid_setup valid=%b count=%0d want 1/3", cmd_valid, fifo_count);
    end
    cyc(4'b0000, 1'b1, 1'b1);
    total++; if (key_now !== 4'b0000) begin bad++; $display("FAIL mid_keys_in_reset got=%b want=0000", key_now); end
    total++; if (cmd_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL mid_after_reset valid=%b count=%0d ovf=%b want 0/0/0", cmd_valid, fifo_count, overflow);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0000, 1'b1, 1'b0);
      if (key_now != 4'b0000) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL mid_ghost_pulses got=%0d want=0", pulses); end
  endtask

  task automatic test_rr_wrap();
    logic [3:0] want_second;
    // shr granted, then shr+add together: add must come next.
    cyc(4'b0000, 1'b1, 1'b1);
    cyc(4'b1000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b1001, 1'b1, 1'b0);
    collect(3, 40);
    total++; if (col_n != 3 || col_key[0] !== 4'b1000 || col_key[1] !== 4'b0001) begin
      bad++; $display("FAIL wrap_add n=%0d first=%b second=%b want 3/1000/0001", col_n, col_key[0], col_key[1]);
    end
    // shr granted, then shr+sub together: sub must come next.
    cyc(4'b0000, 1'b1, 1'b1);
    cyc(4'b1000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b1010, 1'b1, 1'b0);
    collect(3, 40);
    total++; if (col_n != 3 || col_key[1] !== 4'b0010 || col_key[2] !== 4'b1000) begin
      bad++; $display("FAIL wrap_sub n=%0d second=%b third=%b want 3/0010/1000", col_n, col_key[1], col_key[2]);
    end
    // add granted, then add+sub together: the two arbitration modes differ here.
`ifdef KEY_CMD_SCHED_FIXED_PRIO_EN
    want_second = 4'b0001;
`else
    want_second = 4'b0010;
`endif
    cyc(4'b0000, 1'b1, 1'b1);
    cyc(4'b0001, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0011, 1'b1, 1'b0);
    collect(3, 40);
    total++; if (col_n != 3 || col_key[1] !== want_second) begin
      bad++; $display("FAIL arb_mode n=%0d second=%b want 3/%b", col_n, col_key[1], want_second);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       rdy;
    logic       rst;
    cyc(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 149) == 0);
      cyc(r, rdy, rst);
      total++; if (key_now !== exp_key) begin
        bad++; $display("FAIL rand_keys cyc=%0d got=%b want=%b", ncyc, key_now, exp_key);
      end
      total++; if (cmd_valid !== m_valid) begin
        bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", ncyc, cmd_valid, m_valid);
      end
      if (m_valid) begin
        total++; if (cmd_code !== m_code) begin
          bad++; $display("FAIL rand_code cyc=%0d got=%0d want=%0d", ncyc, cmd_code, m_code);
        end
      end
      total++; if (fifo_count !== 3'(m_q.size())) begin
        bad++; $display("FAIL rand_count cyc=%0d got=%0d want=%0d", ncyc, fifo_count, m_q.size());
      end
      total++; if (overflow !== m_ovf) begin
        bad++; $display("FAIL rand_overflow cyc=%0d got=%b want=%b", ncyc, overflow, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_hold_overflow();
    test_reset_mid_issue();
    test_rr_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
